// File: rtl/cordic_vector.sv
// -----------------------------------------------------------------------------
// cordic_vector
//
// Iterative CORDIC in vectoring mode. It computes atan2(y_in, x_in) and the
// length of the vector (x_in, y_in) using one micro-rotation per clock,
// 16 rotations per result.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous, active-low reset
//   x_in       in  18   signed Q2.16 vector X
//   y_in       in  18   signed Q2.16 vector Y
//   start      in   1   request; accepted only in IDLE or DONE
//   angle      out 19   signed Q3.16 atan2(y_in, x_in), range [-pi, +pi]
//   magnitude  out 20   unsigned Q4.16 vector length
//   busy       out  1   computation in progress
//   done       out  1   result valid; held until the next accepted start
//
// Configuration
//   CORDIC_GAIN_COMP_EN  When defined, an extra COMP state scales x by 1/K
//                        (39797 in Q0.16) with half-up rounding, which adds
//                        one cycle of latency. When undefined, magnitude is
//                        the raw CORDIC x, which carries the gain K ~= 1.64676.
//
// Latency: done rises 16 edges after the capture edge (17 with compensation).
// -----------------------------------------------------------------------------
module cordic_vector (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [17:0] x_in,
  input  logic signed [17:0] y_in,
  input  logic               start,
  output logic signed [18:0] angle,
  output logic        [19:0] magnitude,
  output logic               busy,
  output logic               done
);

  localparam logic signed [18:0] PI_Q16 = 19'sd205887;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [16:0] INV_K_Q16 = 17'd39797;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
`ifdef CORDIC_GAIN_COMP_EN
    , S_COMP = 2'd3
`endif
  } state_e;

  // atan(2^-i) in Q2.16.
  function automatic logic signed [18:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 19'sd51472;
      4'd1:    atan_lut = 19'sd30386;
      4'd2:    atan_lut = 19'sd16055;
      4'd3:    atan_lut = 19'sd8150;
      4'd4:    atan_lut = 19'sd4091;
      4'd5:    atan_lut = 19'sd2047;
      4'd6:    atan_lut = 19'sd1024;
      4'd7:    atan_lut = 19'sd512;
      4'd8:    atan_lut = 19'sd256;
      4'd9:    atan_lut = 19'sd128;
      4'd10:   atan_lut = 19'sd64;
      4'd11:   atan_lut = 19'sd32;
      4'd12:   atan_lut = 19'sd16;
      4'd13:   atan_lut = 19'sd8;
      4'd14:   atan_lut = 19'sd4;
      default: atan_lut = 19'sd2;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic        [3:0]  iter_q, iter_d;
  logic signed [20:0] x_q, x_d;
  logic signed [20:0] y_q, y_d;
  logic signed [18:0] z_q, z_d;
  logic               zero_q, zero_d;
  logic signed [18:0] angle_q, angle_d;
  logic        [19:0] mag_q, mag_d;

  logic signed [20:0] x_ext, y_ext;
  logic signed [20:0] x_sh, y_sh;
  logic signed [20:0] x_rot, y_rot;
  logic signed [18:0] z_rot;
  logic signed [18:0] atan_i;
  logic               last_iter;

  assign angle     = angle_q;
  assign magnitude = mag_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register in the design samples the values that existed before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign last_iter = (iter_q == 4'd15);

  // NOTE: every variable driven in a combinational block gets a default at the
  // top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_ITER;
      S_ITER: begin
        if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_COMP;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_COMP:  state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_ITER: busy = 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
      S_COMP: busy = 1'b1;
`endif
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // One micro-rotation. The direction drives y toward zero while z accumulates
  // the angle rotated away, so z converges to the input angle.
  always_comb begin
    x_ext  = {{3{x_in[17]}}, x_in};
    y_ext  = {{3{y_in[17]}}, y_in};
    x_sh   = x_q >>> iter_q;
    y_sh   = y_q >>> iter_q;
    atan_i = atan_lut(iter_q);
    if (!y_q[20]) begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_i;
    end else begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_i;
    end
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          iter_d = 4'd0;
          // The CORDIC only converges within +/-pi/2, so left-half-plane
          // vectors are mirrored through the origin and z starts at +/-pi.
          zero_d = (x_in == '0) && (y_in == '0);
          if (x_in[17]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = y_in[17] ? -PI_Q16 : PI_Q16;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end
        end
      end
      S_ITER: begin
        x_d    = x_rot;
        y_d    = y_rot;
        z_d    = z_rot;
        iter_d = iter_q + 4'd1;
`ifndef CORDIC_GAIN_COMP_EN
        // A zero vector has no defined angle; the captured flag forces an
        // exact zero result instead of whatever the rotations produced.
        if (last_iter) begin
          angle_d = zero_q ? '0 : z_rot;
          mag_d   = zero_q ? '0 : x_rot[19:0];
        end
`endif
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_COMP: begin
        // x is non-negative after the mirroring, so an unsigned product is
        // safe. Q4.16 * Q0.16 = Q4.32; add half an output LSB, keep [3:-16].
        angle_d = zero_q ? '0 : z_q;
        mag_d   = zero_q ? '0 :
                  20'((({17'd0, x_q} * {21'd0, INV_K_Q16}) + 38'd32768) >> 16);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// -----------------------------------------------------------------------------
// tb_cordic_vector
//
// Self-checking bench for cordic_vector. Expected results come from a real-
// valued model (atan2, sqrt, CORDIC gain) pushed to a scoreboard when an
// operation is started and popped when done rises. Build with
// +define+CORDIC_GAIN_COMP_EN to check the compensated variant.
// -----------------------------------------------------------------------------
module tb_cordic_vector;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT      = 17;
  localparam bit GAIN_CMP = 1'b1;
`else
  localparam int LAT      = 16;
  localparam bit GAIN_CMP = 1'b0;
`endif
  localparam int ANG_TOL = 16;
  localparam int MAG_TOL = 32;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [17:0] x_in  = '0;
  logic signed [17:0] y_in  = '0;
  logic signed [18:0] angle;
  logic        [19:0] magnitude;
  logic               busy;
  logic               done;

  typedef struct {
    int ang;
    int mag;
    bit exact;
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  real  gain     = 1.0;

  cordic_vector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_in      (x_in),
    .y_in      (y_in),
    .start     (start),
    .angle     (angle),
    .magnitude (magnitude),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    e.x     = x;
    e.y     = y;
    e.exact = (x == 0) && (y == 0);
    e.ang   = e.exact ? 0 : int'($atan2(real'(y), real'(x)) * 65536.0);
    e.mag   = int'($sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * gain);
    return e;
  endfunction

  // Drives a one-cycle start; returns at the falling edge after the capture
  // edge (edge 0).
  task automatic start_op(input string tag, input int x, input int y);
    @(negedge clk);
    x_in  = 18'(x);
    y_in  = 18'(y);
    start = 1'b1;
    sb.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL %s_accept: busy=%b done=%b required busy=1 done=0", tag, busy, done);
    else pass_cnt++;
  endtask

  // n0 = number of edges already elapsed since the capture edge.
  task automatic wait_result(input string tag, input int n0);
    int   n;
    int   a;
    int   m;
    int   da;
    int   dm;
    exp_t e;
    n = n0;
    while (done !== 1'b1 && n < LAT + 20) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (n != LAT) $display("FAIL %s_latency: done after %0d edges required %0d", tag, n, LAT);
    else pass_cnt++;
    chk_cnt++;
    if (sb.size() == 0) begin
      $display("FAIL %s_scoreboard: queue empty required one entry", tag);
      return;
    end
    pass_cnt++;
    e  = sb.pop_front();
    a  = int'(angle);
    m  = int'(magnitude);
    da = (a > e.ang) ? a - e.ang : e.ang - a;
    dm = (m > e.mag) ? m - e.mag : e.mag - m;
    chk_cnt++;
    if (e.exact ? (a != 0) : (da > ANG_TOL))
      $display("FAIL %s_angle (x=%0d y=%0d): got %0d required %0d tol %0d",
               tag, e.x, e.y, a, e.ang, e.exact ? 0 : ANG_TOL);
    else pass_cnt++;
    chk_cnt++;
    if (e.exact ? (m != 0) : (dm > MAG_TOL))
      $display("FAIL %s_magnitude (x=%0d y=%0d): got %0d required %0d tol %0d",
               tag, e.x, e.y, m, e.mag, e.exact ? 0 : MAG_TOL);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || angle !== '0 || magnitude !== '0)
      $display("FAIL reset_state: busy=%b done=%b angle=%0d mag=%0d required all 0",
               busy, done, angle, magnitude);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int vx[7] = '{65536, 32768, -65536,      0, -50000,  131071, -131072};
    int vy[7] = '{    0, 32768,      0, -65536, -70000, -131072,  131071};
    for (int i = 0; i < 7; i++) begin
      start_op("basic", vx[i], vy[i]);
      wait_result("basic", 0);
    end
  endtask

  task automatic test_random();
    int x;
    int y;
    for (int i = 0; i < 6; i++) begin
      do begin
        x = int'($urandom_range(262143)) - 131072;
        y = int'($urandom_range(262143)) - 131072;
      end while (((x < 0) ? -x : x) + ((y < 0) ? -y : y) < 16384);
      start_op("random", x, y);
      wait_result("random", 0);
    end
  endtask

  task automatic test_zero();
    start_op("zero", 0, 0);
    wait_result("zero", 0);
  endtask

  task automatic test_ignore_start();
    logic signed [18:0] prev_a;
    logic        [19:0] prev_m;
    prev_a = angle;
    prev_m = magnitude;
    start_op("ignore", 32768, -32768);
    repeat (4) @(negedge clk);
    x_in  = -18'sd90000;
    y_in  = 18'sd70000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL ignore_busy: busy=%b done=%b required busy=1 done=0", busy, done);
    else pass_cnt++;
    chk_cnt++;
    if (angle !== prev_a || magnitude !== prev_m)
      $display("FAIL ignore_hold: angle=%0d mag=%0d required %0d %0d",
               angle, magnitude, prev_a, prev_m);
    else pass_cnt++;
    wait_result("ignore", 5);
  endtask

  task automatic test_reset_abort();
    exp_t dropped;
    start_op("abort", 40000, 20000);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    dropped = sb.pop_back();
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || angle !== '0 || magnitude !== '0)
      $display("FAIL abort_reset: busy=%b done=%b angle=%0d mag=%0d required all 0",
               busy, done, angle, magnitude);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || magnitude !== '0)
      $display("FAIL abort_no_partial (x=%0d): done=%b busy=%b mag=%0d required 0 0 0",
               dropped.x, done, busy, magnitude);
    else pass_cnt++;
    start_op("post_reset", -30000, 45000);
    wait_result("post_reset", 0);
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    x_in  = 18'sd65536;
    y_in  = 18'sd0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || magnitude !== '0)
      $display("FAIL reset_priority: busy=%b done=%b mag=%0d required 0 0 0",
               busy, done, magnitude);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0)
      $display("FAIL reset_priority_idle: busy=%b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    start_op("b2b_first", 65536, 32768);
    wait_result("b2b_first", 0);
    start_op("b2b_second", 0, 65536);
    wait_result("b2b_second", 0);
    start_op("b2b_third", -65536, -1000);
    wait_result("b2b_third", 0);
  endtask

  initial begin
    real p;
    p = 1.0;
    if (!GAIN_CMP) begin
      for (int i = 0; i < 16; i++) begin
        gain = gain * $sqrt(1.0 + p);
        p    = p / 4.0;
      end
    end
    test_reset();
    test_basic();
    test_zero();
    test_ignore_start();
    test_reset_abort();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
